// File: rtl/comparator_4bit_bh_pkg.sv
// ============================================================================
// Module      : comparator_4bit_bh_pkg
// Description : Cascade-flag type and one-hot {EQ,GT,LT} encodings shared by
//               the comparator top and its bit cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_4bit_bh_pkg;

  // Field order matches the one-hot output encoding {EQ,GT,LT}.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_casc_t;

  localparam cmp_casc_t CASC_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};
  localparam cmp_casc_t CASC_EQ   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
  localparam cmp_casc_t CASC_GT   = '{eq: 1'b0, gt: 1'b1, lt: 1'b0};
  localparam cmp_casc_t CASC_LT   = '{eq: 1'b0, gt: 1'b0, lt: 1'b1};

endpackage : comparator_4bit_bh_pkg

`default_nettype wire

// File: rtl/comparator_4bit_bh_cmp_bit_cell.sv
// ============================================================================
// Module      : cmp_bit_cell
// Description : One-bit magnitude-compare cascade cell; the first differing
//               bit seen from the MSB side decides the ordering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_bit_cell
  import comparator_4bit_bh_pkg::*;
(
  input  logic      ai,
  input  logic      bi,
  input  cmp_casc_t prev,
  output cmp_casc_t next
);

  always_comb begin
    next = prev;
    if (prev.eq && (ai != bi)) begin
      next = ai ? CASC_GT : CASC_LT;
    end
  end

endmodule : cmp_bit_cell

`default_nettype wire

// File: rtl/comparator_4bit_bh.sv
// ============================================================================
// Module      : comparator_4bit_bh
// Description : Registered WIDTH-bit magnitude comparator, unsigned or signed,
//               driving one-hot EQ/GT/LT one cycle after the operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_4bit_bh
  import comparator_4bit_bh_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  // Flipping both sign bits maps two's complement onto offset binary, so the
  // unsigned cascade then orders signed operands correctly.
  localparam logic [WIDTH-1:0] SIGN_FLIP =
      SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : {WIDTH{1'b0}};

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  cmp_casc_t        chain [WIDTH:0];
  cmp_casc_t        flags;

  assign a_cmp        = a ^ SIGN_FLIP;
  assign b_cmp        = b ^ SIGN_FLIP;
  assign chain[WIDTH] = CASC_EQ;

  for (genvar gi = WIDTH - 1; gi >= 0; gi--) begin : g_cell
    cmp_bit_cell u_cell (
      .ai   (a_cmp[gi]),
      .bi   (b_cmp[gi]),
      .prev (chain[gi+1]),
      .next (chain[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= CASC_NONE;
    end else begin
      flags <= chain[0];
    end
  end

  assign EQ = flags.eq;
  assign GT = flags.gt;
  assign LT = flags.lt;

endmodule : comparator_4bit_bh

`default_nettype wire

// File: tb/tb_comparator_4bit_bh.sv
// ============================================================================
// Module      : tb_comparator_4bit_bh
// Description : Scoreboard bench driving an unsigned and a signed 4-bit
//               comparator with the same operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_4bit_bh;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } item_t;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'd0;
  logic [3:0] b   = 4'd0;
  logic       eq_u, gt_u, lt_u;
  logic       eq_s, gt_s, lt_s;

  int    vectors    = 0;
  int    miscompares = 0;
  item_t sb [$];

  comparator_4bit_bh #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u (
    .clk (clk), .rst (rst), .EQ (eq_u), .GT (gt_u), .LT (lt_u), .a (a), .b (b)
  );

  comparator_4bit_bh #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
    .clk (clk), .rst (rst), .EQ (eq_s), .GT (gt_s), .LT (lt_s), .a (a), .b (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {EQ,GT,LT}=%b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: every edge with a pending expectation yields one comparison pair.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      item_t it;
      it = sb.pop_front();
      check($sformatf("unsigned a=%h b=%h", it.a, it.b), {eq_u, gt_u, lt_u}, it.exp_u);
      check($sformatf("signed a=%h b=%h", it.a, it.b), {eq_s, gt_s, lt_s}, it.exp_s);
    end
  end

  task automatic apply(input logic [3:0] va, input logic [3:0] vb,
                       input logic [2:0] eu, input logic [2:0] es);
    item_t it;
    a = va;
    b = vb;
    it.a = va; it.b = vb; it.exp_u = eu; it.exp_s = es;
    sb.push_back(it);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] ref_flags(input int x, input int y);
    if (x == y) return F_EQ;
    return (x > y) ? F_GT : F_LT;
  endfunction

  initial begin
    // Hand-computed table: {a, b, unsigned flags, signed flags}.
    item_t dir [10];
    dir[0] = '{4'h5, 4'h3, F_GT, F_GT};
    dir[1] = '{4'h3, 4'h5, F_LT, F_LT};
    dir[2] = '{4'h4, 4'h4, F_EQ, F_EQ};
    dir[3] = '{4'h0, 4'h0, F_EQ, F_EQ};
    dir[4] = '{4'hF, 4'hF, F_EQ, F_EQ};
    dir[5] = '{4'hF, 4'h0, F_GT, F_LT};
    dir[6] = '{4'h0, 4'hF, F_LT, F_GT};
    dir[7] = '{4'h8, 4'h7, F_GT, F_LT};
    dir[8] = '{4'h7, 4'h8, F_LT, F_GT};
    dir[9] = '{4'h8, 4'hF, F_LT, F_LT};

    rst = 1'b1;
    a   = 4'h5;
    b   = 4'h3;
    repeat (3) @(posedge clk);
    #2;
    check("reset unsigned", {eq_u, gt_u, lt_u}, 3'b000);
    check("reset signed",   {eq_s, gt_s, lt_s}, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(dir[i].a, dir[i].b, dir[i].exp_u, dir[i].exp_s);
    end

    // Reset between edges must clear the flags without waiting for a clock.
    #1 rst = 1'b1;
    #1;
    check("async reset unsigned", {eq_u, gt_u, lt_u}, 3'b000);
    check("async reset signed",   {eq_s, gt_s, lt_s}, 3'b000);
    @(posedge clk);
    #1;
    check("held reset unsigned", {eq_u, gt_u, lt_u}, 3'b000);
    rst = 1'b0;

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        int sx, sy;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        apply(4'(x), 4'(y), ref_flags(x, y), ref_flags(sx, sy));
      end
    end

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_comparator_4bit_bh

`default_nettype wire
